// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART definitions: state encoding, baud divisor, parity.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clocks per bit; the receiver uses the same divisor so both ends agree.
  function automatic int baud_cnt_max(input int clk_fre, input int baud);
    return clk_fre / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return odd ? ~^b : ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_if
// Brief  : Byte handshake and serial line bundle for the UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_tx_if;

  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output data, data_valid,
    input  data_ready, tx, busy, tx_done
  );

  modport slave (
    input  data, data_valid,
    output data_ready, tx, busy, tx_done
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module : uart_baud_gen
// Brief  : CNT_MAX-clock bit timer; bit_tick marks the last clock of a bit.
// Rev    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
  parameter int CNT_MAX = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign bit_tick = (cnt_q == W'(CNT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : UART transmitter, 8 data bits LSB first, optional parity, 1/2 stop.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD       = 9600,
  parameter int CLK_FRE    = 50_000_000,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int   BAUD_CNT_MAX = baud_cnt_max(CLK_FRE, BAUD);
  localparam logic STOP_LAST    = (STOP_BITS == 2);

  if (BAUD_CNT_MAX < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FRE/BAUD must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        baud_clr;
  logic        bit_tick;

  // Holding the timer clear while idle makes every frame start on a full bit.
  assign baud_clr = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CNT_MAX (BAUD_CNT_MAX)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.data_valid && ready_q) begin
          state_d    = ST_START;
          shift_d    = bus.data;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
          parity_d   = parity_bit(bus.data, PARITY_ODD != 0);
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the bit about to be on the wire, so tx never glitches.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_q;
      default:   tx_d = 1'b1;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.data_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;

endmodule
`default_nettype wire
